cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Two-requester front end for the direct-mapped cache read port (`read`/`addr`/`read_data`/`hit`).
- Accepts read requests from two independent masters (e.g. fetch and load paths) and arbitrates round-robin.
- Sequences each cache access: issue a one-cycle read pulse, wait the cache latency, capture data/hit, return it to the owning requester.
- Sits between the requesters and the cache instance; the only block that drives the cache `read`/`addr`.

Parameters:
- ADDR_W, 11, request/cache address width.
- DATA_W, 11, cache read-data width.
- CACHE_LAT, 2, cycles from the cache_read-high cycle to the last cycle before data/hit are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req0_valid  input  1  requester 0 has a request; addr held stable until accepted
- req0_addr  input  ADDR_W  requester 0 read address
- req0_ready  output  1  one-cycle accept strobe for requester 0
- rsp0_valid  output  1  one-cycle response strobe for requester 0
- rsp0_data  output  DATA_W  response data for requester 0
- rsp0_hit  output  1  cache hit flag for requester 0 response
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_hit  as above, for requester 1
- cache_read  output  1  read pulse to cache
- cache_addr  output  ADDR_W  address to cache
- cache_read_data  input  DATA_W  cache data
- cache_hit  input  1  cache hit flag
- busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (rst=0, async): state=IDLE; rr pointer=0 (requester 0 favoured); all outputs 0, including cache_addr and rsp*_data.
- IDLE:
  - If any reqN_valid is high, grant one requester: the only valid one, or on a tie the one the rr pointer selects.
  - reqN_ready is high combinationally for the granted requester in this cycle only.
  - On the clock edge: latch the address and the grant id, then go to ISSUE.
- ISSUE: one cycle; cache_read=1 and cache_addr=latched addr. Next state is WAIT, or RESP if CACHE_LAT=1.
- WAIT:
  - Down-counter loaded with CACHE_LAT-1 in ISSUE; lasts CACHE_LAT-1 cycles.
  - cache_read=0; cache_addr held.
  - On the edge ending the final WAIT cycle (or ending ISSUE when CACHE_LAT=1), register cache_read_data/cache_hit into the granted requester's rsp_data/rsp_hit, then go to RESP.
- RESP:
  - rspN_valid=1 for exactly one cycle for the granted requester.
  - rr pointer is set to favour the other requester.
  - Next state is IDLE.
- Latency and throughput:
  - Accept in cycle 0, cache_read in cycle 1, rsp_valid in cycle CACHE_LAT+1.
  - Next accept no earlier than cycle CACHE_LAT+2, so one access per CACHE_LAT+2 cycles.
- rspN_data/rspN_hit hold their value until that requester's next response; the other requester's outputs are never disturbed.
- reqN_ready is never asserted outside IDLE, and never for both requesters in the same cycle.
- Requester dropping reqN_valid before it is accepted: the request is withdrawn with no effect.
- Reset mid-operation: the transaction is aborted with no rsp strobe. A still-valid requester is re-accepted after reset, with requester 0 first.
- Back-to-back from one requester while the other is idle: that requester is served every CACHE_LAT+2 cycles; the rr pointer does not block it.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (synchronous, active-high).
  - Adds outputs hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1, each 16 bits.
  - The matching counter increments in each RESP cycle and saturates at 16'hFFFF.
  - All counters reset to 0 on rst and clear on stats_clr; stats_clr wins over an increment in the same cycle.
- Undefined: these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Single request, empty cache: req0 addr=34 → req0_ready in cycle 0; cache_read=1 with cache_addr=34 in cycle 1 only; rsp0_valid=1 in cycle 3 with rsp0_hit=0; busy low again in cycle 4.
- Repeat hit: req0 addr=34 again → rsp0_hit=1 and rsp0_data equals the cache output for 34; rsp1_* unchanged.
- Contention:
  - req0=200 and req1=512 both valid from reset → req0 served first and req1 accepted at the next IDLE.
  - Then both valid again (34, 528) → req1 has priority once req0 was last served, giving alternation 0,1,0,1.
- Conflict miss: req1=512 then req1=768 then req1=512 → hit pattern 0,0,0.
- Reset mid-operation: assert rst=0 during WAIT → all outputs 0 immediately and no rsp strobe; with req0_valid still high after release, the access re-runs with the full latency.
- ARB_STATS_EN:
  - The 10-access sequence 34,34,200,34,512,528,34,200,768,34 on req0 → counters match the hit pattern of the cache-under-test; miss_cnt1=hit_cnt1=0.
  - stats_clr pulse → all counters 0 on the next cycle.

Source files
------------

// File: rtl/cache_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter_if
//
// Purpose:
//   Bundles the request/response handshakes of the two cache requesters and the
//   cache read port into one interface for cache_req_arbiter.
//
// Signals:
//   req0_valid/req0_addr/req0_ready            requester 0 request handshake
//   rsp0_valid/rsp0_data/rsp0_hit              requester 0 response
//   req1_* / rsp1_*                            same, for requester 1
//   cache_read/cache_addr                      read pulse and address to cache
//   cache_read_data/cache_hit                  data and hit flag from cache
//   busy                                       arbiter is not idle
//
// Modports:
//   slave  - the arbiter itself
//   master - its environment (both requesters plus the cache instance)
// -----------------------------------------------------------------------------
interface cache_req_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 11
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic              req0_ready;
   logic              rsp0_valid;
   logic [DATA_W-1:0] rsp0_data;
   logic              rsp0_hit;

   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic              req1_ready;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp1_data;
   logic              rsp1_hit;

   logic              cache_read;
   logic [ADDR_W-1:0] cache_addr;
   logic [DATA_W-1:0] cache_read_data;
   logic              cache_hit;

   logic              busy;

   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr,
      input  cache_read_data, cache_hit,
      output req0_ready, rsp0_valid, rsp0_data, rsp0_hit,
      output req1_ready, rsp1_valid, rsp1_data, rsp1_hit,
      output cache_read, cache_addr, busy
   );

   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr,
      output cache_read_data, cache_hit,
      input  req0_ready, rsp0_valid, rsp0_data, rsp0_hit,
      input  req1_ready, rsp1_valid, rsp1_data, rsp1_hit,
      input  cache_read, cache_addr, busy
   );
endinterface

// File: rtl/cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter
//
// Purpose:
//   Two-requester front end for the direct-mapped cache read port. Grants one
//   request at a time (round-robin on contention), issues a single-cycle read
//   pulse, waits the cache latency, captures data/hit and returns them to the
//   owning requester with a one-cycle response strobe.
//
//   Timing per access (cycle 0 = accept):
//     cycle 0            reqN_ready
//     cycle 1            cache_read, cache_addr = latched address
//     cycles 2..LAT      wait (cache_addr held)
//     cycle LAT+1        rspN_valid with captured data/hit
//     cycle LAT+2        earliest next accept
//
// Parameters:
//   ADDR_W     request/cache address width
//   DATA_W     cache read-data width
//   CACHE_LAT  cycles from the cache_read cycle to the last cycle before
//              data/hit are sampled (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   bus        cache_req_arbiter_if.slave (requesters + cache port + busy)
//
// Optional feature (macro ARB_STATS_EN):
//   stats_clr  synchronous active-high clear of the statistics counters
//   hit_cnt0/miss_cnt0/hit_cnt1/miss_cnt1
//              16-bit saturating per-requester hit/miss counters, bumped in
//              each response cycle
//   With the macro undefined these ports and counters do not exist.
// -----------------------------------------------------------------------------
module cache_req_arbiter #(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 11,
   parameter int CACHE_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   cache_req_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
   ,
   input  logic                stats_clr,
   output logic [15:0]         hit_cnt0,
   output logic [15:0]         miss_cnt0,
   output logic [15:0]         hit_cnt1,
   output logic [15:0]         miss_cnt1
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // WAIT lasts CACHE_LAT-1 cycles; the counter holds the cycles still to go.
   localparam logic [3:0] WAIT_LOAD = 4'(CACHE_LAT - 1);
   localparam bit         LAT_ONE   = (CACHE_LAT == 1);

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic              rr_reg;        // requester favoured on a tie
   logic              grant_id_reg;  // owner of the access in flight
   logic [ADDR_W-1:0] addr_reg;
   logic [3:0]        wait_cnt_reg;

   // Per-requester views of the interface so the per-requester logic can be
   // generated once.
   logic              req_valid [2];
   logic [ADDR_W-1:0] req_addr  [2];
   logic              req_ready [2];
   logic              rsp_valid [2];
   logic [DATA_W-1:0] rsp_data  [2];
   logic              rsp_hit   [2];

   logic grant_any;
   logic grant_sel;
   logic capture_now;

   assign req_valid[0] = bus.req0_valid;
   assign req_valid[1] = bus.req1_valid;
   assign req_addr[0]  = bus.req0_addr;
   assign req_addr[1]  = bus.req1_addr;

   // Arbitration: a lone requester always wins, so the rr pointer only
   // matters when both are valid in the same IDLE cycle.
   assign grant_any = req_valid[0] || req_valid[1];
   assign grant_sel = (req_valid[0] && req_valid[1]) ? rr_reg : req_valid[1];

   // The cache result is sampled on the edge that ends the last WAIT cycle,
   // or the ISSUE cycle when there is no WAIT at all.
   assign capture_now = (LAT_ONE && (state_reg == ST_ISSUE)) ||
                        (!LAT_ONE && (state_reg == ST_WAIT) && (wait_cnt_reg == 4'd1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (grant_any) state_next = ST_ISSUE;
         ST_ISSUE: state_next = LAT_ONE ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (wait_cnt_reg == 4'd1) state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         rr_reg       <= 1'b0;
         grant_id_reg <= 1'b0;
         addr_reg     <= '0;
         wait_cnt_reg <= 4'd0;
      end else begin
         state_reg <= state_next;

         if ((state_reg == ST_IDLE) && grant_any) begin
            addr_reg     <= req_addr[grant_sel];
            grant_id_reg <= grant_sel;
         end

         if (state_reg == ST_ISSUE) begin
            wait_cnt_reg <= WAIT_LOAD;
         end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
         end

         if (state_reg == ST_RESP) begin
            rr_reg <= ~grant_id_reg;
         end
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] hit_cnt  [2];
   logic [15:0] miss_cnt [2];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         logic [DATA_W-1:0] data_reg;
         logic              hit_reg;

         // Gated by rst so a requester holding valid through reset never sees
         // an accept while the block is held in reset.
         assign req_ready[gi] = rst && (state_reg == ST_IDLE) && grant_any &&
                                (grant_sel == 1'(gi));
         assign rsp_valid[gi] = (state_reg == ST_RESP) && (grant_id_reg == 1'(gi));

         // Only the owner's response registers load; the other requester's
         // last response stays visible.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               data_reg <= '0;
               hit_reg  <= 1'b0;
            end else if (capture_now && (grant_id_reg == 1'(gi))) begin
               data_reg <= bus.cache_read_data;
               hit_reg  <= bus.cache_hit;
            end
         end

         assign rsp_data[gi] = data_reg;
         assign rsp_hit[gi]  = hit_reg;

`ifdef ARB_STATS_EN
         logic [15:0] hit_cnt_reg;
         logic [15:0] miss_cnt_reg;

         // hit_reg already holds this response's flag during RESP.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hit_cnt_reg  <= 16'd0;
               miss_cnt_reg <= 16'd0;
            end else if (stats_clr) begin
               hit_cnt_reg  <= 16'd0;
               miss_cnt_reg <= 16'd0;
            end else if (rsp_valid[gi]) begin
               if (hit_reg) begin
                  if (hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
               end else begin
                  if (miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 16'd1;
               end
            end
         end

         assign hit_cnt[gi]  = hit_cnt_reg;
         assign miss_cnt[gi] = miss_cnt_reg;
`endif
      end
   endgenerate

   assign bus.req0_ready = req_ready[0];
   assign bus.req1_ready = req_ready[1];
   assign bus.rsp0_valid = rsp_valid[0];
   assign bus.rsp1_valid = rsp_valid[1];
   assign bus.rsp0_data  = rsp_data[0];
   assign bus.rsp1_data  = rsp_data[1];
   assign bus.rsp0_hit   = rsp_hit[0];
   assign bus.rsp1_hit   = rsp_hit[1];

   assign bus.cache_read = (state_reg == ST_ISSUE);
   assign bus.cache_addr = addr_reg;
   assign bus.busy       = (state_reg != ST_IDLE);

`ifdef ARB_STATS_EN
   assign hit_cnt0  = hit_cnt[0];
   assign miss_cnt0 = miss_cnt[0];
   assign hit_cnt1  = hit_cnt[1];
   assign miss_cnt1 = miss_cnt[1];
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_req_arbiter
//
// Drives cache_req_arbiter with directed request sequences, models a
// 256-line direct-mapped cache (index = addr[7:0], tag = addr[10:8]) behind
// it, and compares every DUT output on every cycle against a transaction-level
// model (accept cycle + fixed offsets). Directed literal checks pin latencies,
// grant order and hit patterns. Honours ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_cache_req_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 11;
   localparam int LAT    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cache_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1;
`endif

   cache_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CACHE_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave)
`ifdef ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .hit_cnt0  (hit_cnt0),
      .miss_cnt0 (miss_cnt0),
      .hit_cnt1  (hit_cnt1),
      .miss_cnt1 (miss_cnt1)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] data_of(input logic [10:0] a);
      return (a * 11'd3) + 11'd21;
   endfunction

   // ---------------- cache under test (bench-owned) ----------------
   // A line is valid when its generation equals cur_gen; bumping cur_gen
   // flushes the cache and the model's shadow copy together.
   int         cur_gen = 1;
   int         c_gen [256];
   logic [2:0] c_tag [256];
   int         m_gen [256];
   logic [2:0] m_tag [256];

   initial begin
      bus.cache_read_data = '0;
      bus.cache_hit       = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.cache_read === 1'b1) begin : lookup
            logic [7:0]  ix;
            logic [10:0] a;
            logic        h;
            a  = bus.cache_addr;
            ix = a[7:0];
            h  = (c_gen[ix] == cur_gen) && (c_tag[ix] == a[10:8]);
            c_gen[ix] = cur_gen;
            c_tag[ix] = a[10:8];
            @(posedge clk);
            #1;
            bus.cache_read_data = data_of(a);
            bus.cache_hit       = h;
         end
      end
   end

   // ---------------- transaction-level model + per-cycle compare ----------------
   int          cyc = 0;
   bit          m_active = 1'b0;
   int          m_acc = 0;
   bit          m_owner = 1'b0;
   logic [10:0] m_caddr = '0;
   bit          m_rr = 1'b0;
   logic [10:0] m_rdata [2];
   bit          m_rhit  [2];
   bit          m_thit = 1'b0;
   logic [10:0] m_tdata = '0;
   int          m_hc [2];
   int          m_mc [2];

   initial begin
      bit e_rdy [2];
      bit e_rv  [2];
      bit e_cr, e_busy, gv, was_active;
      int k;
      logic [10:0] a;
      forever begin
         @(negedge clk);
         cyc++;
         e_rdy = '{1'b0, 1'b0};
         e_rv  = '{1'b0, 1'b0};
         e_cr  = 1'b0;
         e_busy = 1'b0;
         gv = 1'b0;
         k = 0;
         was_active = m_active;
         if (!rst) begin
            m_active = 1'b0;
            was_active = 1'b0;
            m_rr = 1'b0;
            m_caddr = '0;
            m_rdata = '{11'd0, 11'd0};
            m_rhit  = '{1'b0, 1'b0};
            m_hc = '{0, 0};
            m_mc = '{0, 0};
         end else begin
            e_busy = m_active;
            if (m_active) begin
               k = cyc - m_acc;
               if (k == 1) begin
                  e_cr = 1'b1;
                  a = m_caddr;
                  m_thit = (m_gen[a[7:0]] == cur_gen) && (m_tag[a[7:0]] == a[10:8]);
                  m_tdata = data_of(a);
                  m_gen[a[7:0]] = cur_gen;
                  m_tag[a[7:0]] = a[10:8];
               end
               if (k == LAT + 1) begin
                  e_rv[m_owner] = 1'b1;
                  m_rdata[m_owner] = m_tdata;
                  m_rhit[m_owner]  = m_thit;
               end
            end else if (bus.req0_valid || bus.req1_valid) begin
               gv = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
               e_rdy[gv] = 1'b1;
            end
         end

         chk("req0_ready", bus.req0_ready, e_rdy[0]);
         chk("req1_ready", bus.req1_ready, e_rdy[1]);
         chk("cache_read", bus.cache_read, e_cr);
         chk("cache_addr", bus.cache_addr, m_caddr);
         chk("rsp0_valid", bus.rsp0_valid, e_rv[0]);
         chk("rsp1_valid", bus.rsp1_valid, e_rv[1]);
         chk("rsp0_data", bus.rsp0_data, m_rdata[0]);
         chk("rsp0_hit", bus.rsp0_hit, m_rhit[0]);
         chk("rsp1_data", bus.rsp1_data, m_rdata[1]);
         chk("rsp1_hit", bus.rsp1_hit, m_rhit[1]);
         chk("busy", bus.busy, e_busy);
`ifdef ARB_STATS_EN
         chk("hit_cnt0", hit_cnt0, m_hc[0]);
         chk("miss_cnt0", miss_cnt0, m_mc[0]);
         chk("hit_cnt1", hit_cnt1, m_hc[1]);
         chk("miss_cnt1", miss_cnt1, m_mc[1]);
`endif

         if (rst) begin
            if (was_active && k == LAT + 1) begin
               m_active = 1'b0;
               m_rr = ~m_owner;
               if (m_rhit[m_owner]) begin
                  if (m_hc[m_owner] < 65535) m_hc[m_owner]++;
               end else begin
                  if (m_mc[m_owner] < 65535) m_mc[m_owner]++;
               end
            end else if (!was_active && (bus.req0_valid || bus.req1_valid)) begin
               m_active = 1'b1;
               m_acc = cyc;
               m_owner = gv;
               m_caddr = gv ? bus.req1_addr : bus.req0_addr;
            end
`ifdef ARB_STATS_EN
            if (stats_clr) begin
               m_hc = '{0, 0};
               m_mc = '{0, 0};
            end
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   int          r_rdy [2];
   int          r_rsp [2];
   int          r_cr;
   bit          g_hit [2];
   logic [10:0] g_data [2];
   int          glog [$];

   logic [10:0] seq_addr [10] = '{11'd34, 11'd34, 11'd200, 11'd34, 11'd512,
                                  11'd528, 11'd34, 11'd200, 11'd768, 11'd34};
   bit          seq_hit  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   // Called at posedge+1; cycle 0 is the first cycle with valid applied.
   task automatic run(input bit v0, input logic [10:0] a0,
                      input bit v1, input logic [10:0] a1);
      bit acc0, acc1, dn0, dn1;
      acc0 = 1'b0; acc1 = 1'b0; dn0 = 1'b0; dn1 = 1'b0;
      r_rdy = '{-1, -1};
      r_rsp = '{-1, -1};
      r_cr  = -1;
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (bus.req0_ready && !acc0) begin acc0 = 1'b1; r_rdy[0] = n; glog.push_back(0); end
         if (bus.req1_ready && !acc1) begin acc1 = 1'b1; r_rdy[1] = n; glog.push_back(1); end
         if (bus.cache_read && r_cr < 0) r_cr = n;
         if (bus.rsp0_valid) begin dn0 = 1'b1; r_rsp[0] = n; g_hit[0] = bus.rsp0_hit; g_data[0] = bus.rsp0_data; end
         if (bus.rsp1_valid) begin dn1 = 1'b1; r_rsp[1] = n; g_hit[1] = bus.rsp1_hit; g_data[1] = bus.rsp1_data; end
         if ((dn0 || !v0) && (dn1 || !v1)) break;
         @(posedge clk);
         #1;
         if (acc0) bus.req0_valid = 1'b0;
         if (acc1) bus.req1_valid = 1'b0;
      end
      chk("run_completed", int'((dn0 || !v0) && (dn1 || !v1)), 1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      bus.req0_valid = 1'b0;
      bus.req0_addr  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_addr  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_cache_addr", bus.cache_addr, 0);
      chk("reset_rsp0_data", bus.rsp0_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single request, empty cache
      run(1'b1, 11'd34, 1'b0, 11'd0);
      $display("txn single: ready@%0d read@%0d rsp@%0d hit=%0d data=%0d", r_rdy[0], r_cr, r_rsp[0], g_hit[0], g_data[0]);
      chk("single_ready_cycle", r_rdy[0], 0);
      chk("single_read_cycle", r_cr, 1);
      chk("single_rsp_cycle", r_rsp[0], 3);
      chk("single_hit", g_hit[0], 0);
      chk("single_data", g_data[0], 123);
      @(negedge clk);
      chk("single_busy_cycle4", bus.busy, 0);
      @(posedge clk);
      #1;

      // Repeat hit
      run(1'b1, 11'd34, 1'b0, 11'd0);
      $display("txn repeat: rsp@%0d hit=%0d data=%0d", r_rsp[0], g_hit[0], g_data[0]);
      chk("repeat_hit", g_hit[0], 1);
      chk("repeat_data", g_data[0], 123);
      chk("repeat_rsp1_data", bus.rsp1_data, 0);
      chk("repeat_rsp1_hit", bus.rsp1_hit, 0);

      // Contention: both valid from reset
      rst = 1'b0;
      glog.delete();
      bus.req0_valid = 1'b1; bus.req0_addr = 11'd200;
      bus.req1_valid = 1'b1; bus.req1_addr = 11'd512;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run(1'b1, 11'd200, 1'b1, 11'd512);
      $display("txn pair1: ready0@%0d ready1@%0d rsp1 data=%0d hit=%0d", r_rdy[0], r_rdy[1], g_data[1], g_hit[1]);
      chk("pair1_ready0_cycle", r_rdy[0], 0);
      chk("pair1_ready1_cycle", r_rdy[1], 4);
      chk("pair1_rsp1_data", g_data[1], 1557);
      chk("pair1_rsp1_hit", g_hit[1], 0);
      run(1'b1, 11'd34, 1'b1, 11'd528);
      $display("txn pair2: ready0@%0d ready1@%0d grants=%0d", r_rdy[0], r_rdy[1], glog.size());
      chk("grant_count", glog.size(), 4);
      if (glog.size() == 4) begin
         chk("grant_order_0", glog[0], 0);
         chk("grant_order_1", glog[1], 1);
         chk("grant_order_2", glog[2], 0);
         chk("grant_order_3", glog[3], 1);
      end

      // Conflict misses on requester 1
      cur_gen++;
      run(1'b0, 11'd0, 1'b1, 11'd512);
      $display("txn conflict 512: hit=%0d", g_hit[1]);
      chk("conflict_a_hit", g_hit[1], 0);
      run(1'b0, 11'd0, 1'b1, 11'd768);
      $display("txn conflict 768: hit=%0d", g_hit[1]);
      chk("conflict_b_hit", g_hit[1], 0);
      run(1'b0, 11'd0, 1'b1, 11'd512);
      $display("txn conflict 512: hit=%0d", g_hit[1]);
      chk("conflict_c_hit", g_hit[1], 0);

      // Reset during WAIT
      cur_gen++;
      bus.req0_addr  = 11'd200;
      bus.req0_valid = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (bus.req0_ready) seen = 1'b1;
      end
      chk("abort_accept_seen", int'(seen), 1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      $display("txn abort: busy=%0d read=%0d rsp0_valid=%0d", bus.busy, bus.cache_read, bus.rsp0_valid);
      chk("abort_busy", bus.busy, 0);
      chk("abort_cache_read", bus.cache_read, 0);
      chk("abort_cache_addr", bus.cache_addr, 0);
      chk("abort_rsp0_valid", bus.rsp0_valid, 0);
      chk("abort_rsp0_data", bus.rsp0_data, 0);
      chk("abort_req0_ready", bus.req0_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run(1'b1, 11'd200, 1'b0, 11'd0);
      $display("txn rerun: ready@%0d rsp@%0d hit=%0d", r_rdy[0], r_rsp[0], g_hit[0]);
      chk("rerun_ready_cycle", r_rdy[0], 0);
      chk("rerun_rsp_cycle", r_rsp[0], 3);
      chk("rerun_hit", g_hit[0], 1);

      // Ten-access sequence on requester 0, back to back
      cur_gen++;
`ifdef ARB_STATS_EN
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      @(negedge clk);
      chk("preclr_hit_cnt0", hit_cnt0, 0);
      chk("preclr_miss_cnt1", miss_cnt1, 0);
      @(posedge clk);
      #1;
`endif
      for (int i = 0; i < 10; i++) begin
         run(1'b1, seq_addr[i], 1'b0, 11'd0);
         $display("txn seq[%0d] addr=%0d: ready@%0d hit=%0d data=%0d", i, seq_addr[i], r_rdy[0], g_hit[0], g_data[0]);
         chk("seq_accept_cycle", r_rdy[0], 0);
         chk("seq_hit", g_hit[0], seq_hit[i]);
      end
`ifdef ARB_STATS_EN
      @(negedge clk);
      $display("txn stats: hit0=%0d miss0=%0d hit1=%0d miss1=%0d", hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1);
      chk("stats_hit_cnt0", hit_cnt0, 5);
      chk("stats_miss_cnt0", miss_cnt0, 5);
      chk("stats_hit_cnt1", hit_cnt1, 0);
      chk("stats_miss_cnt1", miss_cnt1, 0);
      @(posedge clk);
      #1;
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      @(negedge clk);
      chk("clr_hit_cnt0", hit_cnt0, 0);
      chk("clr_miss_cnt0", miss_cnt0, 0);
      @(posedge clk);
      #1;
`endif

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
